// File: rtl/alu_wb_queue.sv
`default_nettype none
// ==========================================================================
// alu_wb_queue: APSR flag register plus ALU writeback FIFO with operand bypass
// Revision: 1.0
// ==========================================================================
module alu_wb_queue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_result,
  input  logic [3:0]                   in_flag_q,
  input  logic [REG_AW-1:0]            in_rd,
  input  logic                         in_we,
  input  logic                         in_setflags,
  output logic [3:0]                   apsr,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [REG_AW-1:0]            wb_rd,
  output logic [DATA_W-1:0]            wb_data,
  input  logic [REG_AW-1:0]            fwd_rs,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [PTR_W:0]   c_depth_ext = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [REG_AW-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        apsr_q, apsr_d;

  logic accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Physical slot holding the entry that is 'age' positions behind the head.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int age);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W + 1)'(age);
    return (sum >= c_depth_ext) ? PTR_W'(sum - c_depth_ext) : PTR_W'(sum);
  endfunction

  // Handshake decisions depend on registered occupancy only.
  assign in_ready = (count_q < c_depth_cnt);
  assign wb_valid = (count_q != '0);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_we;
  assign pop      = wb_valid && wb_ready;

  assign wb_rd    = rd_q[head_q];
  assign wb_data  = data_q[head_q];
  assign apsr     = apsr_q;
  assign count    = count_q;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    apsr_d  = apsr_q;

    if (accept && in_setflags) begin
      apsr_d = in_flag_q;
    end

    // Push and pop never target the same slot: that would need count 0 or DEPTH.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = in_rd;
      data_d[tail_q]  = in_result;
      tail_d          = ptr_inc(tail_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      apsr_q  <= 4'b0000;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      apsr_q  <= apsr_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  // Walk oldest to youngest so the last match is the youngest producer.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[slot_of(head_q, i)] && (rd_q[slot_of(head_q, i)] == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[slot_of(head_q, i)];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_wb_queue.md
Name: alu_wb_queue

Overview:
- Downstream neighbour of the ALU, in the execute→writeback path.
- Holds the architectural APSR flags (N,Z,C,V), which feed the ALU's flag input.
- Queues ALU results bound for the register-file write port, which can stall (port shared with load data).
- Provides a combinational forwarding lookup so decode/operand fetch can bypass results not yet written back.

Parameters:
DATA_W, 32, result/data width
REG_AW, 4, register index width (r0-r15)
DEPTH, 2, writeback queue entries (legal 1..4)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ALU result presented this cycle
in_ready  out  1  queue can accept
in_result  in  DATA_W  ALU result
in_flag_q  in  4  ALU flag_q {N,Z,C,V}
in_rd  in  REG_AW  destination register
in_we  in  1  result must be written to in_rd
in_setflags  in  1  commit in_flag_q to APSR (S-suffix instruction)
apsr  out  4  current {N,Z,C,V}, drives ALU flag input
wb_valid  out  1  head entry available for register file
wb_ready  in  1  register-file port grants write this cycle
wb_rd  out  REG_AW  head destination
wb_data  out  DATA_W  head data
fwd_rs  in  REG_AW  register being read by operand fetch
fwd_hit  out  1  a queued entry targets fwd_rs
fwd_data  out  DATA_W  data of youngest queued entry with rd==fwd_rs
count  out  clog2(DEPTH+1)  occupancy, for debug/stall logic

Behaviour:
- Reset (rst sampled high at edge): count=0, apsr=4'b0000, all entry valid bits cleared. Outputs: in_ready=1, wb_valid=0, fwd_hit=0. Contents of wb_rd, wb_data, fwd_data are don't-care while their valid is low.
- Reset mid-operation discards all queued entries; no writeback is issued for them.
- in_ready = (count < DEPTH), a function of registered state only; no combinational path from in_valid or wb_ready.
- Accept: accept = in_valid && in_ready.
  - On accept with in_setflags=1: apsr <= in_flag_q at that edge; visible on apsr the next cycle (1-cycle latency).
  - The APSR update is independent of in_we and of queue draining; flags commit in issue order regardless of writeback stalls.
  - On accept with in_we=1: entry {in_rd, in_result} is pushed at the tail.
  - On accept with in_we=0: nothing is queued; only the APSR may change.
  - When in_ready=0, inputs are ignored: no APSR change, no push.
- Queue is FIFO, circular head/tail pointers wrapping modulo DEPTH.
  - wb_valid = (count != 0); wb_rd/wb_data are taken from the head entry, registered storage only.
  - Pop when wb_valid && wb_ready; head advances at the edge.
  - wb_valid && !wb_ready holds wb_rd/wb_data stable.
  - Same-cycle push and pop: count unchanged, both pointers advance. Push is impossible when full, since in_ready=0.
  - Zero-latency bypass from input to wb is NOT provided: an accepted entry appears on wb_* no earlier than the next cycle.
- Forwarding (combinational over valid queue entries only):
  - fwd_hit=1 iff some valid entry has rd==fwd_rs.
  - fwd_data comes from the youngest such entry (closest to tail).
  - An entry popped this cycle still counts as a hit in this cycle.
  - The in_* input is not forwarded.
- Multiple queued entries to the same rd are permitted; they drain in order, so the last write wins in the register file.
- rd=15 is queued like any other register; no special handling here.
- Arithmetic: count is a plain up/down counter saturating by construction at 0..DEPTH; pointers increment and wrap from DEPTH-1 to 0.

Test Plan:
- Reset, then in_valid=1, in_we=1, in_rd=3, in_result=32'h0000_00AA, in_setflags=1, in_flag_q=4'b0100 for one cycle -> next cycle wb_valid=1, wb_rd=3, wb_data=0xAA, apsr=4'b0100, count=1; with wb_ready=1 it pops and count returns to 0.
- DEPTH=2, wb_ready=0, push r1=0x11 then r2=0x22 -> count=2, in_ready=0. A third in_valid with setflags=1, flag_q=4'b1000 is ignored (apsr unchanged). Set wb_ready=1 -> wb outputs r1/0x11, then r2/0x22, then wb_valid=0.
- Full queue with wb_ready=1 held and in_valid every cycle -> in_ready toggles per occupancy. Over 20 pushes, the exact sequence of values emerges in order with no loss or duplication, exercising pointer wrap.
- Push r5=0x1, then r5=0x2 with wb_ready=0; fwd_rs=5 -> fwd_hit=1, fwd_data=0x2. fwd_rs=6 -> fwd_hit=0. After both drain -> fwd_hit=0.
- in_we=0, in_setflags=1, flag_q=4'b0011 while queue holds 1 stalled entry -> apsr=4'b0011 next cycle, count unchanged. Then in_setflags=0, flag_q=4'b1111 -> apsr stays 4'b0011.
- Queue holding 2 entries, assert rst for one cycle concurrently with in_valid=1 and wb_ready=1 -> next cycle count=0, wb_valid=0, apsr=0, fwd_hit=0, and no pop occurred.
